// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit between a pipeline and a simple request/acknowledge memory bus.
//   A request is checked for size legality and alignment in IDLE. A valid request
//   latches the bus address, byte enables and lane-replicated store data and holds
//   them in WAIT until the memory acks or the wait budget runs out. Load data is
//   lane-shifted, truncated to the access size and sign/zero-extended on capture.
//   The unit then spends one DONE cycle before returning to IDLE.
//
// Parameters
//   W        data/address width, 32 or 64
//   TIMEOUT  WAIT cycles allowed without ack before the access is aborted (2..255)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_read_en          load request from the pipeline
//   mem_write_en         store request from the pipeline
//   mem_size             00 byte, 01 half, 10 word, 11 double (W=64 only)
//   mem_unsigned         1: zero-extend loads, 0: sign-extend loads
//   mem_addr             effective address
//   mem_write_data       store data (right-aligned)
//   mem_read_data        formatted load result, held until the next capture
//   stall                pipeline must hold its inputs while high
//   addr_err             invalid request presented in IDLE (combinational)
//   bus_err              one-cycle pulse when an access times out
//   bus_req/bus_we       bus request / write strobe
//   bus_addr             width-aligned bus address
//   bus_be               byte-lane enables, little-endian
//   bus_wdata            lane-replicated store data
//   bus_rdata, bus_ack   read data and acknowledge from memory

module mem_access_unit #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mem_read_en,
  input  logic           mem_write_en,
  input  logic [1:0]     mem_size,
  input  logic           mem_unsigned,
  input  logic [W-1:0]   mem_addr,
  input  logic [W-1:0]   mem_write_data,
  output logic [W-1:0]   mem_read_data,
  output logic           stall,
  output logic           addr_err,
  output logic           bus_err,
  output logic           bus_req,
  output logic           bus_we,
  output logic [W-1:0]   bus_addr,
  output logic [W/8-1:0] bus_be,
  output logic [W-1:0]   bus_wdata,
  input  logic [W-1:0]   bus_rdata,
  input  logic           bus_ack
);

  localparam int unsigned BW   = W / 8;
  localparam int unsigned OFFW = (W == 64) ? 3 : 2;
  localparam logic [7:0]  LastWait = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e          state_q;
  logic [7:0]      wait_cnt_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [W-1:0]    bus_addr_q;
  logic [BW-1:0]   bus_be_q;
  logic [W-1:0]    bus_wdata_q;
  logic [W-1:0]    rdata_q;
  logic            bus_err_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [OFFW-1:0] off_q;

  logic [OFFW-1:0] off;
  logic            misaligned;
  logic            size_ok;
  logic            req_any;
  logic            valid_req;
  logic [BW-1:0]   be_nxt;
  logic [W-1:0]    wdata_rep;
  logic [W-1:0]    rdata_shift;
  logic [W-1:0]    rdata_fmt;

  // Request decode

  assign off     = mem_addr[OFFW-1:0];
  assign req_any = mem_read_en | mem_write_en;
  assign size_ok = (mem_size != 2'b11) || (W == 64);

  always_comb begin
    misaligned = 1'b0;
    unique case (mem_size)
      2'b00: misaligned = 1'b0;
      2'b01: misaligned = mem_addr[0];
      2'b10: misaligned = |mem_addr[1:0];
      2'b11: misaligned = |mem_addr[2:0];
    endcase
  end

  // Exactly one enable, a size this width supports, and natural alignment.
  assign valid_req = (mem_read_en ^ mem_write_en) && size_ok && !misaligned;

  assign addr_err = (state_q == StIdle) && req_any && !valid_req;
  assign stall    = ((state_q == StIdle) && valid_req) || (state_q == StWait);

  // Store path: byte enables and lane replication

  always_comb begin
    be_nxt = '0;
    unique case (mem_size)
      2'b00: be_nxt = BW'(1) << off;
      2'b01: be_nxt = BW'(3) << off;
      2'b10: be_nxt = BW'(15) << off;
      2'b11: be_nxt = '1;
    endcase
  end

  always_comb begin
    wdata_rep = mem_write_data;
    unique case (mem_size)
      2'b00: wdata_rep = {BW{mem_write_data[7:0]}};
      2'b01: wdata_rep = {(W/16){mem_write_data[15:0]}};
      2'b10: wdata_rep = {(W/32){mem_write_data[31:0]}};
      2'b11: wdata_rep = mem_write_data;
    endcase
  end

  // Load path: move the addressed lane to bit 0, then truncate and extend

  assign rdata_shift = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    rdata_fmt = rdata_shift;
    unique case (size_q)
      2'b00: rdata_fmt = unsigned_q ? W'(rdata_shift[7:0])  : W'($signed(rdata_shift[7:0]));
      2'b01: rdata_fmt = unsigned_q ? W'(rdata_shift[15:0]) : W'($signed(rdata_shift[15:0]));
      2'b10: rdata_fmt = unsigned_q ? W'(rdata_shift[31:0]) : W'($signed(rdata_shift[31:0]));
      2'b11: rdata_fmt = rdata_shift;
    endcase
  end

  // Control FSM with registered bus-side outputs

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      off_q       <= '0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_req) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write_en;
            bus_addr_q  <= {mem_addr[W-1:OFFW], {OFFW{1'b0}}};
            bus_be_q    <= be_nxt;
            bus_wdata_q <= wdata_rep;
            size_q      <= mem_size;
            unsigned_q  <= mem_unsigned;
            off_q       <= off;
            wait_cnt_q  <= '0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              rdata_q <= rdata_fmt;
            end
            state_q <= StDone;
          end else if (wait_cnt_q == LastWait) begin
            // Budget spent: abort and report; stale load data is not left behind.
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            rdata_q   <= '0;
            state_q   <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_err       = bus_err_q;
  assign mem_read_data = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (W=32, TIMEOUT=16). Inputs change on the
// falling edge; outputs are sampled 1ns after it.

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_en, mem_write_en;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        stall, addr_err, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  int vectors = 0;
  int miscompares = 0;

  // Results of the most recent do_access call
  int          s_cnt, r_cnt;
  logic [3:0]  be_s;
  logic [31:0] addr_s, wdata_s;
  logic        we_s, err_s, stable_s, done_s;

  always #5 clk = ~clk;

  mem_access_unit #(.W(32), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_size       (mem_size),
    .mem_unsigned   (mem_unsigned),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .stall          (stall),
    .addr_err       (addr_err),
    .bus_err        (bus_err),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one request from IDLE and plays memory: acks in WAIT cycle ack_cycle
  // (0 = never). Returns in IDLE at a falling edge. drop_en withdraws the
  // enables and scrambles the address once WAIT is reached.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_cycle, input logic drop_en);
    logic seen_wait;
    seen_wait = 1'b0;
    s_cnt = 0; r_cnt = 0; be_s = '0; addr_s = '0; wdata_s = '0; we_s = 1'b0;
    err_s = 1'b0; stable_s = 1'b1; done_s = 1'b0;
    mem_read_en = rd; mem_write_en = wr; mem_size = size; mem_unsigned = uns;
    mem_addr = addr; mem_write_data = wdata;
    for (int c = 0; c < 40 && !done_s; c++) begin
      #1;
      if (stall) s_cnt++;
      if (bus_err) err_s = 1'b1;
      if (bus_req) begin
        if (!seen_wait) begin
          be_s = bus_be; addr_s = bus_addr; wdata_s = bus_wdata; we_s = bus_we;
        end else if ({bus_be, bus_addr, bus_wdata, bus_we} !== {be_s, addr_s, wdata_s, we_s}) begin
          stable_s = 1'b0;
        end
        seen_wait = 1'b1;
        r_cnt++;
        bus_ack   = (r_cnt == ack_cycle);
        bus_rdata = rdata;
        if (drop_en) begin
          mem_read_en = 1'b0; mem_write_en = 1'b0; mem_addr = addr ^ 32'h0000_0F00;
        end
      end else begin
        bus_ack = 1'b0;
        if (seen_wait && !stall) begin
          mem_read_en = 1'b0; mem_write_en = 1'b0;
          done_s = 1'b1;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read_en = 1'b0; mem_write_en = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    mem_addr = '0; mem_write_data = '0; bus_rdata = '0; bus_ack = 1'b0;
    tick(); tick();
    #1;
    vectors++;
    if ({bus_req, bus_we, bus_err, stall, addr_err, bus_be} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {bus_req, bus_we, bus_err, stall, addr_err, bus_be}, 9'b0);
    end
    vectors++;
    if ({bus_addr, bus_wdata, mem_read_data} !== 96'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h expected all zero",
               bus_addr, bus_wdata, mem_read_data);
    end
    // Valid request while held in reset: stall follows inputs, no bus request.
    mem_read_en = 1'b1; mem_size = 2'b10;
    tick();
    #1;
    vectors++;
    if ({stall, bus_req} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_req_held: got stall,bus_req=%b expected 10", {stall, bus_req});
    end
    mem_read_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_byte();
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 1, 1'b0);
    vectors++;
    if ({done_s, be_s, addr_s, we_s, err_s} !== {1'b1, 4'b1000, 32'h0000_1000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL lb_bus: got done=%b be=%b addr=%h we=%b err=%b expected 1 1000 00001000 0 0",
               done_s, be_s, addr_s, we_s, err_s);
    end
    vectors++;
    if (mem_read_data !== 32'hFFFF_FF80) begin
      miscompares++;
      $display("FAIL lb_data: got %h expected ffffff80", mem_read_data);
    end
    vectors++;
    if (s_cnt !== 2 || r_cnt !== 1) begin
      miscompares++;
      $display("FAIL lb_latency: got stall=%0d req=%0d expected 2 1", s_cnt, r_cnt);
    end
  endtask

  task automatic test_store_half();
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h1111_2222, 1, 1'b0);
    vectors++;
    if ({done_s, be_s, addr_s, we_s} !== {1'b1, 4'b1100, 32'h0000_2000, 1'b1}) begin
      miscompares++;
      $display("FAIL sh_bus: got done=%b be=%b addr=%h we=%b expected 1 1100 00002000 1",
               done_s, be_s, addr_s, we_s);
    end
    vectors++;
    if (wdata_s !== 32'hBEEF_BEEF) begin
      miscompares++;
      $display("FAIL sh_wdata: got %h expected beefbeef", wdata_s);
    end
    vectors++;
    if (mem_read_data !== 32'hFFFF_FF80) begin
      miscompares++;
      $display("FAIL sh_rdata_hold: got %h expected ffffff80", mem_read_data);
    end
  endtask

  task automatic test_addr_err();
    logic [35:0] vec [4];
    // {read_en, write_en, size, addr}
    vec[0] = {1'b1, 1'b0, 2'b10, 32'h0000_3001};  // misaligned word
    vec[1] = {1'b1, 1'b0, 2'b11, 32'h0000_3000};  // double on a 32-bit unit
    vec[2] = {1'b1, 1'b1, 2'b00, 32'h0000_3000};  // both enables
    vec[3] = {1'b0, 1'b1, 2'b01, 32'h0000_3005};  // misaligned half store
    for (int i = 0; i < 4; i++) begin
      {mem_read_en, mem_write_en, mem_size, mem_addr} = vec[i];
      #1;
      vectors++;
      if ({addr_err, stall, bus_req} !== 3'b100) begin
        miscompares++;
        $display("FAIL addr_err_%0d: got err,stall,req=%b expected 100", i,
                 {addr_err, stall, bus_req});
      end
      tick();
      #1;
      vectors++;
      if (bus_req !== 1'b0) begin
        miscompares++;
        $display("FAIL addr_err_noreq_%0d: got bus_req=%b expected 0", i, bus_req);
      end
      mem_read_en = 1'b0; mem_write_en = 1'b0;
      tick();
    end
  endtask

  task automatic test_load_half_unsigned();
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0, 32'h9ABC_1234, 3, 1'b0);
    vectors++;
    if (mem_read_data !== 32'h0000_9ABC) begin
      miscompares++;
      $display("FAIL lhu_data: got %h expected 00009abc", mem_read_data);
    end
    vectors++;
    if (s_cnt !== 4 || r_cnt !== 3 || be_s !== 4'b1100 || stable_s !== 1'b1) begin
      miscompares++;
      $display("FAIL lhu_timing: got stall=%0d req=%0d be=%b stable=%b expected 4 3 1100 1",
               s_cnt, r_cnt, be_s, stable_s);
    end
  endtask

  task automatic test_ack_outside();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    #1;
    vectors++;
    if ({bus_req, stall, mem_read_data} !== {2'b00, 32'h0000_9ABC}) begin
      miscompares++;
      $display("FAIL ack_idle: got req=%b stall=%b data=%h expected 0 0 00009abc",
               bus_req, stall, mem_read_data);
    end
    bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_load_half_signed();
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_7000, 32'h0, 32'h0000_8001, 1, 1'b0);
    vectors++;
    if (mem_read_data !== 32'hFFFF_8001 || be_s !== 4'b0011) begin
      miscompares++;
      $display("FAIL lh_signed: got data=%h be=%b expected ffff8001 0011", mem_read_data, be_s);
    end
  endtask

  task automatic test_reset_in_wait();
    mem_read_en = 1'b1; mem_write_en = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    mem_addr = 32'h0000_5000;
    tick();
    tick();
    #1;
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_wait_pre: got bus_req=%b expected 1", bus_req);
    end
    rst_n = 1'b0;
    mem_read_en = 1'b0;
    #1;
    vectors++;
    if ({bus_req, bus_err, bus_we, bus_be, bus_addr, mem_read_data} !== 71'b0) begin
      miscompares++;
      $display("FAIL rst_wait_clear: got req=%b err=%b be=%b addr=%h data=%h expected zeros",
               bus_req, bus_err, bus_be, bus_addr, mem_read_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0, 32'h1234_5678, 1, 1'b0);
    vectors++;
    if ({mem_read_data, err_s} !== {32'h1234_5678, 1'b0} || s_cnt !== 2) begin
      miscompares++;
      $display("FAIL rst_wait_next: got data=%h err=%b stall=%0d expected 12345678 0 2",
               mem_read_data, err_s, s_cnt);
    end
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5008, 32'h0, 32'h1111_1111, 0, 1'b0);
    vectors++;
    if ({done_s, err_s} !== 2'b11 || r_cnt !== 16 || s_cnt !== 17) begin
      miscompares++;
      $display("FAIL timeout_seq: got done=%b err=%b req=%0d stall=%0d expected 1 1 16 17",
               done_s, err_s, r_cnt, s_cnt);
    end
    #1;
    vectors++;
    if ({mem_read_data, bus_err, bus_req} !== 34'b0) begin
      miscompares++;
      $display("FAIL timeout_after: got data=%h err=%b req=%b expected 0 0 0",
               mem_read_data, bus_err, bus_req);
    end
  endtask

  task automatic test_store_word_drop_en();
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_9000, 32'hDEAD_BEEF, 32'h0, 2, 1'b1);
    vectors++;
    if ({done_s, be_s, addr_s, wdata_s, we_s, stable_s} !==
        {1'b1, 4'b1111, 32'h0000_9000, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL sw_hold: got done=%b be=%b addr=%h wdata=%h we=%b stable=%b",
               done_s, be_s, addr_s, wdata_s, we_s, stable_s);
    end
    vectors++;
    if (r_cnt !== 2 || s_cnt !== 3) begin
      miscompares++;
      $display("FAIL sw_timing: got req=%0d stall=%0d expected 2 3", r_cnt, s_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_8001, 32'h0000_00A5, 32'h0, 1, 1'b0);
    vectors++;
    if ({be_s, wdata_s, we_s} !== {4'b0010, 32'hA5A5_A5A5, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_store: got be=%b wdata=%h we=%b expected 0010 a5a5a5a5 1",
               be_s, wdata_s, we_s);
    end
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_8001, 32'h0, 32'h0000_A500, 1, 1'b0);
    vectors++;
    if ({mem_read_data, be_s, we_s} !== {32'h0000_00A5, 4'b0010, 1'b0} || s_cnt !== 2) begin
      miscompares++;
      $display("FAIL b2b_load: got data=%h be=%b we=%b stall=%0d expected 000000a5 0010 0 2",
               mem_read_data, be_s, we_s, s_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_addr_err();
    test_load_half_unsigned();
    test_ack_outside();
    test_load_half_signed();
    test_reset_in_wait();
    test_timeout();
    test_store_word_drop_en();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
